// File: rtl/ysyx_24090018_regfile_sb.sv
// ysyx_24090018_regfile_sb
// Integer register file for the JX500 core with a per-register busy
// scoreboard. Decode reserves a destination through the issue handshake,
// and the writeback port releases it. x0 always reads as zero and is never
// busy. Reads are combinational, so the read ports return the current
// register value and busy bit in the same cycle.
//
// Optional feature: define YSYX_24090018_RF_BYPASS_EN to forward the
// writeback port straight to any read port that addresses the register
// being written. In that case the read returns the new data and a clear
// busy flag. Without the macro, reads return the pre-edge state.
// Scoreboard and issue behaviour are the same in both builds.

module ysyx_24090018_regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wen,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
    output logic [NUM_READ-1:0]            rbusy,
    input  logic                           issue_valid,
    input  logic [ADDR_WIDTH-1:0]          issue_rd,
    output logic                           issue_ready,
    input  logic                           flush,
    output logic [ADDR_WIDTH:0]            busy_cnt
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    // Population count of a busy vector. x0 is never busy, so the result
    // fits in ADDR_WIDTH+1 bits.
    function automatic logic [ADDR_WIDTH:0] busy_popcount(input logic [NREGS-1:0] vec);
        logic [ADDR_WIDTH:0] cnt;
        cnt = {(ADDR_WIDTH+1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + {{ADDR_WIDTH{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    logic [DATA_WIDTH-1:0] rf_q [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic [ADDR_WIDTH:0]   busy_cnt_q;

    logic                  wr_en_s;
    logic                  issue_ready_s;
    logic                  issue_acc_s;
    logic [NREGS-1:0]      rel_mask_s;
    logic [NREGS-1:0]      set_mask_s;

    // A write to x0 is discarded, so it neither changes data nor releases x0.
    assign wr_en_s = wen && (waddr != {ADDR_WIDTH{1'b0}});

    // Issue readiness: x0 is always free. A busy register becomes free in
    // the same cycle if writeback is releasing it.
    always_comb begin
        issue_ready_s = 1'b0;
        if (issue_rd == {ADDR_WIDTH{1'b0}}) begin
            issue_ready_s = 1'b1;
        end else if (!busy_q[issue_rd]) begin
            issue_ready_s = 1'b1;
        end else if (wr_en_s && (waddr == issue_rd)) begin
            issue_ready_s = 1'b1;
        end else begin
            issue_ready_s = 1'b0;
        end
    end

    // A reservation of x0 is accepted as a handshake but reserves nothing.
    assign issue_acc_s = issue_valid && issue_ready_s
                         && (issue_rd != {ADDR_WIDTH{1'b0}});

    assign rel_mask_s = wr_en_s
                        ? ({{(NREGS-1){1'b0}}, 1'b1} << waddr)
                        : {NREGS{1'b0}};
    assign set_mask_s = issue_acc_s
                        ? ({{(NREGS-1){1'b0}}, 1'b1} << issue_rd)
                        : {NREGS{1'b0}};

    // Next busy vector. The set is applied after the release, so it wins
    // when both target the same register. A flush drops everything,
    // including a same-cycle reservation.
    always_comb begin
        busy_d = {NREGS{1'b0}};
        if (flush) begin
            busy_d = {NREGS{1'b0}};
        end else begin
            busy_d = (busy_q & ~rel_mask_s) | set_mask_s;
        end
        busy_d[0] = 1'b0;
    end

    // Register data storage. A flush does not affect data writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            rf_q[waddr] <= wdata;
        end
    end

    // Scoreboard state. The busy count is registered alongside the busy
    // vector, so it always matches it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= {NREGS{1'b0}};
            busy_cnt_q <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_popcount(busy_d);
        end
    end

    assign issue_ready = issue_ready_s;
    assign busy_cnt    = busy_cnt_q;

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_s;
        logic [DATA_WIDTH-1:0] rd_s;
        logic                  rb_s;

        assign ra_s = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

        // Combinational read port. x0 reads as zero and not busy, and the
        // optional forward path takes precedence over stored state.
        always_comb begin
            rd_s = {DATA_WIDTH{1'b0}};
            rb_s = 1'b0;
            if (ra_s == {ADDR_WIDTH{1'b0}}) begin
                rd_s = {DATA_WIDTH{1'b0}};
                rb_s = 1'b0;
`ifdef YSYX_24090018_RF_BYPASS_EN
            end else if (wr_en_s && (ra_s == waddr)) begin
                rd_s = wdata;
                rb_s = 1'b0;
`endif
            end else begin
                rd_s = rf_q[ra_s];
                rb_s = busy_q[ra_s];
            end
        end

        assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = rd_s;
        assign rbusy[g]                          = rb_s;
    end

endmodule

// File: tb/tb_ysyx_24090018_regfile_sb.sv
// Self-checking bench for ysyx_24090018_regfile_sb (default parameters).
// Expected values go into a queue when stimulus is driven. They are popped
// and compared against the DUT once the outputs have settled.

module tb_ysyx_24090018_regfile_sb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;

    localparam int S_RD0  = 0;
    localparam int S_RD1  = 1;
    localparam int S_RB0  = 2;
    localparam int S_RB1  = 3;
    localparam int S_CNT  = 4;
    localparam int S_RDY  = 5;

    logic              clk;
    logic              rst_n;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic              issue_ready;
    logic              flush;
    logic [AW:0]       busy_cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_err;

    ysyx_24090018_regfile_sb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_READ  (NR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .flush      (flush),
        .busy_cnt   (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD0:   return rdata[31:0];
            S_RD1:   return rdata[63:32];
            S_RB0:   return {31'd0, rbusy[0]};
            S_RB1:   return {31'd0, rbusy[1]};
            S_CNT:   return {26'd0, busy_cnt};
            S_RDY:   return {31'd0, issue_ready};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_val(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen         = 1'b0;
        waddr       = 5'd0;
        wdata       = 32'd0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        flush       = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic do_issue(input logic [AW-1:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        tick();
        idle();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        set_rd(5'd0, 5'd0);
        #1;

        // Reset held for two edges.
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            set_rd(i[4:0], 5'(31 - i));
            issue_rd = i[4:0];
            expect_val("rst_rd0", S_RD0, 32'd0);
            expect_val("rst_rd1", S_RD1, 32'd0);
            expect_val("rst_rb0", S_RB0, 32'd0);
            expect_val("rst_rb1", S_RB1, 32'd0);
            expect_val("rst_cnt", S_CNT, 32'd0);
            expect_val("rst_rdy", S_RDY, 32'd1);
            drain();
            tick();
        end
        idle();

        // Write/read, and a write to x0 that must be ignored.
        do_write(5'd5, 32'hDEAD_BEEF);
        set_rd(5'd5, 5'd0);
        expect_val("wr_x5", S_RD0, 32'hDEAD_BEEF);
        expect_val("wr_x0_rd", S_RD1, 32'd0);
        drain();
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        expect_val("x0_during_wr", S_RD1, 32'd0);
        drain();
        tick();
        idle();
        expect_val("x0_after_wr", S_RD1, 32'd0);
        expect_val("x0_cnt", S_CNT, 32'd0);
        drain();

        // Scoreboard: reserve, blocked re-issue, release with same-cycle reserve.
        set_rd(5'd7, 5'd0);
        issue_valid = 1'b1; issue_rd = 5'd7;
        expect_val("iss7_rdy", S_RDY, 32'd1);
        drain();
        tick();
        idle();
        expect_val("iss7_busy", S_RB0, 32'd1);
        expect_val("iss7_cnt", S_CNT, 32'd1);
        drain();
        issue_valid = 1'b1; issue_rd = 5'd7;
        expect_val("iss7_again_rdy", S_RDY, 32'd0);
        drain();
        tick();
        idle();
        expect_val("iss7_hold_busy", S_RB0, 32'd1);
        expect_val("iss7_hold_cnt", S_CNT, 32'd1);
        expect_val("iss7_hold_data", S_RD0, 32'd0);
        drain();
        wen = 1'b1; waddr = 5'd7; wdata = 32'h0000_0012;
        issue_valid = 1'b1; issue_rd = 5'd7;
        expect_val("relset_rdy", S_RDY, 32'd1);
        drain();
        tick();
        idle();
        expect_val("relset_data", S_RD0, 32'h0000_0012);
        expect_val("relset_busy", S_RB0, 32'd1);
        expect_val("relset_cnt", S_CNT, 32'd1);
        drain();
        do_write(5'd7, 32'h0000_0034);
        expect_val("rel7_busy", S_RB0, 32'd0);
        expect_val("rel7_cnt", S_CNT, 32'd0);
        expect_val("rel7_data", S_RD0, 32'h0000_0034);
        drain();

        // Release and reservation of different registers in the same cycle.
        do_issue(5'd8);
        wen = 1'b1; waddr = 5'd8; wdata = 32'h0000_0088;
        issue_valid = 1'b1; issue_rd = 5'd11;
        tick();
        idle();
        set_rd(5'd8, 5'd11);
        expect_val("diff_rel8", S_RB0, 32'd0);
        expect_val("diff_set11", S_RB1, 32'd1);
        expect_val("diff_cnt", S_CNT, 32'd1);
        drain();
        do_write(5'd11, 32'h0000_00BB);

        // Flush with a same-cycle reservation and data write.
        do_issue(5'd1);
        do_issue(5'd2);
        do_issue(5'd3);
        expect_val("fl_pre_cnt", S_CNT, 32'd3);
        drain();
        flush = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd4;
        wen = 1'b1; waddr = 5'd3; wdata = 32'h0000_0033;
        tick();
        idle();
        set_rd(5'd4, 5'd3);
        expect_val("fl_cnt", S_CNT, 32'd0);
        expect_val("fl_x4_busy", S_RB0, 32'd0);
        expect_val("fl_x3_busy", S_RB1, 32'd0);
        expect_val("fl_x3_data", S_RD1, 32'h0000_0033);
        drain();

        // Fill every register and check the count ceiling. x0 reserves nothing.
        for (int i = 1; i < 32; i++) begin
            do_issue(i[4:0]);
        end
        do_issue(5'd0);
        set_rd(5'd0, 5'd31);
        expect_val("full_cnt", S_CNT, 32'd31);
        expect_val("full_x0_busy", S_RB0, 32'd0);
        expect_val("full_x31_busy", S_RB1, 32'd1);
        drain();
        flush = 1'b1;
        tick();
        idle();
        expect_val("full_flush_cnt", S_CNT, 32'd0);
        drain();

        // Write forwarding versus pre-edge read.
        do_write(5'd9, 32'h1111_1111);
        do_issue(5'd9);
        set_rd(5'd9, 5'd0);
        wen = 1'b1; waddr = 5'd9; wdata = 32'hA5A5_A5A5;
`ifdef YSYX_24090018_RF_BYPASS_EN
        expect_val("byp_data", S_RD0, 32'hA5A5_A5A5);
        expect_val("byp_busy", S_RB0, 32'd0);
`else
        expect_val("byp_data", S_RD0, 32'h1111_1111);
        expect_val("byp_busy", S_RB0, 32'd1);
`endif
        drain();
        tick();
        idle();
        expect_val("byp_next_data", S_RD0, 32'hA5A5_A5A5);
        expect_val("byp_next_busy", S_RB0, 32'd0);
        expect_val("byp_next_cnt", S_CNT, 32'd0);
        drain();

        // Reset in the middle of operation.
        do_issue(5'd10);
        set_rd(5'd10, 5'd12);
        expect_val("mid_pre_busy", S_RB0, 32'd1);
        expect_val("mid_pre_cnt", S_CNT, 32'd1);
        drain();
        rst_n = 1'b0;
        wen = 1'b1; waddr = 5'd10; wdata = 32'h0000_00BB;
        issue_valid = 1'b1; issue_rd = 5'd12;
        tick();
        rst_n = 1'b1;
        idle();
        expect_val("mid_x10_data", S_RD0, 32'd0);
        expect_val("mid_x10_busy", S_RB0, 32'd0);
        expect_val("mid_x12_busy", S_RB1, 32'd0);
        expect_val("mid_cnt", S_CNT, 32'd0);
        drain();
        set_rd(5'd5, 5'd9);
        expect_val("mid_x5_clr", S_RD0, 32'd0);
        expect_val("mid_x9_clr", S_RD1, 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_24090018_regfile_sb.md
Name: ysyx_24090018_regfile_sb

Overview:
- Parametrised integer register file for the JX500 core: configurable register count, data width and number of combinational read ports.
- Carries a per-register scoreboard of busy bits. The decode stage reserves a destination at issue; the writeback port releases it.
- Read ports report both data and busy, so decode can detect RAW hazards and issue can block WAW hazards without external state.
- x0 is hard-wired to zero and is never busy.

Parameters:
- ADDR_WIDTH, 5, register index width; register count NREGS = 2**ADDR_WIDTH (RV32E build uses 4).
- DATA_WIDTH, 32, register data width.
- NUM_READ, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- wen  in  1  writeback enable.
- waddr  in  ADDR_WIDTH  writeback register index.
- wdata  in  DATA_WIDTH  writeback data.
- raddr  in  NUM_READ*ADDR_WIDTH  packed read indices; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NUM_READ*DATA_WIDTH  packed read data, same packing.
- rbusy  out  NUM_READ  per-port busy flag of the addressed register.
- issue_valid  in  1  decode requests reservation of issue_rd.
- issue_rd  in  ADDR_WIDTH  destination to reserve.
- issue_ready  out  1  reservation may be accepted this cycle.
- flush  in  1  clears all busy bits (pipeline squash).
- busy_cnt  out  ADDR_WIDTH+1  number of registers currently busy.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - all registers 0 and all busy bits 0, so busy_cnt=0.
  - wen, issue_valid and flush are ignored that cycle.
  - Reset mid-operation discards pending reservations.
- Write:
  - when wen=1 and waddr!=0, rf[waddr] <= wdata at the clock edge, i.e. 1-cycle latency.
  - The same edge clears busy[waddr].
  - wen with waddr=0 has no effect.
- Read:
  - combinational, zero latency: rdata[i] = rf[raddr[i]], rbusy[i] = busy[raddr[i]].
  - raddr[i]=0 always returns data 0 and rbusy 0.
- Issue handshake:
  - issue_ready = !busy[issue_rd] OR (wen AND waddr==issue_rd), i.e. a same-cycle release frees the slot.
  - issue_rd=0 is always ready and reserves nothing.
  - Reservation is accepted when issue_valid AND issue_ready AND issue_rd!=0; busy[issue_rd] <= 1 at the edge.
  - issue_valid with issue_ready=0 changes nothing; decode holds the request.
- Simultaneous events, same edge:
  - Release and accepted reservation of the same register: the set wins, busy stays 1; data is still written.
  - Release and reservation of different registers: both take effect.
  - flush=1: all busy bits <= 0; a same-cycle reservation is dropped; a same-cycle write still updates data.
- busy_cnt:
  - registered; the next value equals the population count of the next busy vector.
  - It never exceeds NREGS-1.

Optional Feature:
- Macro: YSYX_24090018_RF_BYPASS_EN.
- Defined: write-through forwarding. When wen=1, waddr!=0 and raddr[i]==waddr, then rdata[i]=wdata and rbusy[i]=0 in the same cycle.
- Not defined: reads return the pre-edge register value and busy bit; the consumer sees the new value one cycle later.
- Scoreboard and issue behaviour are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then read all indices → rdata=0, rbusy=0, busy_cnt=0, issue_ready=1.
- Write/read: write 0xDEADBEEF to x5; next cycle raddr0=5, raddr1=0 → rdata0=0xDEADBEEF, rdata1=0. Write to x0 → x0 still reads 0.
- Scoreboard: issue x7, next cycle rbusy for x7=1, busy_cnt=1. Issue x7 again → issue_ready=0 and state unchanged. Writeback x7=0x12 with issue of x7 in the same cycle → accepted, busy stays 1, rf[7]=0x12.
- Flush: reserve x1, x2, x3 (busy_cnt=3). Assert flush with issue x4 → busy_cnt=0, x4 not busy.
- Bypass: wen=1, waddr=9, wdata=0xA5A5A5A5, raddr0=9 in the same cycle.
  - With YSYX_24090018_RF_BYPASS_EN: rdata0=0xA5A5A5A5, rbusy0=0.
  - Without it: the old value is returned, and the new value appears next cycle.
- Reset mid-operation: reserve x10, then rst_n=0 with wen to x10 in the same cycle → x10=0 and not busy.
